// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS voice scheduler.
package dds_pkg;

  localparam int unsigned DDS_NUM_VOICES = 8;
  localparam int unsigned DDS_VOICE_W    = 8;
  localparam int unsigned DDS_CODE_W     = 32;
  localparam int unsigned WRCNT_W        = 16;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_PHASE  = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_WRITE  = 2'd3
  } pipe_state_t;

  // The rotation is a fixed 4-slot ring; ST_WRITE wraps back to ST_ACCUM.
  function automatic pipe_state_t next_pipe_state(input pipe_state_t s);
    pipe_state_t n;
    case (s)
      ST_ACCUM:  n = ST_PHASE;
      ST_PHASE:  n = ST_LOOKUP;
      ST_LOOKUP: n = ST_WRITE;
      default:   n = ST_ACCUM;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dds_req_slot.sv
// Single-entry holding register for one tuning-write requester.
// Ready is a flop so it never depends combinationally on valid.
module dds_req_slot
  import dds_pkg::*;
#(
  parameter int unsigned VOICE_W = DDS_VOICE_W,
  parameter int unsigned CODE_W  = DDS_CODE_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid,
  input  logic [VOICE_W-1:0] i_voice,
  input  logic [CODE_W-1:0]  i_code,
  input  logic               i_grant,
  output logic               o_ready,
  output logic               o_pending,
  output logic [VOICE_W-1:0] o_voice,
  output logic [CODE_W-1:0]  o_code
);

  logic               r_pending;
  logic               r_ready;
  logic [VOICE_W-1:0] r_voice;
  logic [CODE_W-1:0]  r_code;
  logic               w_xfer;

  assign w_xfer = i_valid & r_ready;

  // A grant only arrives while pending, so ready is low and no refill can race it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_voice   <= '0;
      r_code    <= '0;
    end else if (i_grant) begin
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
    end else if (w_xfer) begin
      r_pending <= 1'b1;
      r_ready   <= 1'b0;
      r_voice   <= i_voice;
      r_code    <= i_code;
    end
  end

  assign o_ready   = r_ready;
  assign o_pending = r_pending;
  assign o_voice   = r_voice;
  assign o_code    = r_code;

endmodule

// File: rtl/dds_voice_scheduler.sv
// Pipeline-slot sequencer, voice sweep and round-robin tuning-write arbiter.
// Optional write counter enabled with `define DDS_SCHED_WRCNT_EN.
module dds_voice_scheduler
  import dds_pkg::*;
#(
  parameter int unsigned NUM_VOICES = DDS_NUM_VOICES,
  parameter int unsigned VOICE_W    = DDS_VOICE_W,
  parameter int unsigned CODE_W     = DDS_CODE_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  output logic [1:0]         o_pipeline_state,
  output logic [VOICE_W-1:0] o_voice_index,
  output logic               o_frame_start,
  input  logic               i_valid_a,
  output logic               o_ready_a,
  input  logic [VOICE_W-1:0] i_voice_a,
  input  logic [CODE_W-1:0]  i_code_a,
  input  logic               i_valid_b,
  output logic               o_ready_b,
  input  logic [VOICE_W-1:0] i_voice_b,
  input  logic [CODE_W-1:0]  i_code_b,
`ifdef DDS_SCHED_WRCNT_EN
  input  logic               i_count_clr,
  output logic [WRCNT_W-1:0] o_write_count,
`endif
  output logic               o_SPI_flag,
  output logic [VOICE_W-1:0] o_SPI_voice_index,
  output logic [CODE_W-1:0]  o_SPI_tuning_code
);

  pipe_state_t        r_state;
  pipe_state_t        w_state_nxt;
  logic [VOICE_W-1:0] r_index;
  logic [VOICE_W-1:0] w_index_nxt;
  logic               r_frame_start;
  logic               w_frame_nxt;
  logic               w_last_voice;

  logic               w_pend_a;
  logic               w_pend_b;
  logic [VOICE_W-1:0] w_voice_a;
  logic [VOICE_W-1:0] w_voice_b;
  logic [CODE_W-1:0]  w_code_a;
  logic [CODE_W-1:0]  w_code_b;

  logic               r_prefer_b;
  logic               w_slot;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_contend;
  logic [VOICE_W-1:0] w_win_voice;
  logic [CODE_W-1:0]  w_win_code;
  logic               w_in_range;
  logic               w_issue;

  logic               r_spi_flag;
  logic [VOICE_W-1:0] r_spi_voice;
  logic [CODE_W-1:0]  r_spi_code;

  assign w_last_voice = (r_index == VOICE_W'(NUM_VOICES - 1));

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_ACCUM;
      r_index       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  // Next slot/voice; the index only moves when leaving ST_WRITE so it spans all four slots.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_frame_nxt = 1'b0;
    if (i_enable) begin
      w_state_nxt = next_pipe_state(r_state);
      if (r_state == ST_WRITE) begin
        w_index_nxt = w_last_voice ? '0 : r_index + VOICE_W'(1);
        w_frame_nxt = w_last_voice;
      end
    end
  end

  dds_req_slot #(
    .VOICE_W (VOICE_W),
    .CODE_W  (CODE_W)
  ) u_slot_a (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid_a),
    .i_voice   (i_voice_a),
    .i_code    (i_code_a),
    .i_grant   (w_grant_a),
    .o_ready   (o_ready_a),
    .o_pending (w_pend_a),
    .o_voice   (w_voice_a),
    .o_code    (w_code_a)
  );

  dds_req_slot #(
    .VOICE_W (VOICE_W),
    .CODE_W  (CODE_W)
  ) u_slot_b (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid_b),
    .i_voice   (i_voice_b),
    .i_code    (i_code_b),
    .i_grant   (w_grant_b),
    .o_ready   (o_ready_b),
    .o_pending (w_pend_b),
    .o_voice   (w_voice_b),
    .o_code    (w_code_b)
  );

  // Grant decision: a lone requester always wins; contention goes to the preferred port.
  always_comb begin
    w_slot      = i_enable && (r_state == ST_WRITE);
    w_contend   = w_pend_a && w_pend_b;
    w_grant_a   = w_slot && w_pend_a && (!w_pend_b || !r_prefer_b);
    w_grant_b   = w_slot && w_pend_b && (!w_pend_a ||  r_prefer_b);
    w_win_voice = w_grant_b ? w_voice_b : w_voice_a;
    w_win_code  = w_grant_b ? w_code_b  : w_code_a;
    w_in_range  = ({1'b0, w_win_voice} < (VOICE_W + 1)'(NUM_VOICES));
    w_issue     = (w_grant_a || w_grant_b) && w_in_range;
  end

  // Out-of-range targets are consumed silently, leaving the SPI bus untouched.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prefer_b  <= 1'b0;
      r_spi_flag  <= 1'b0;
      r_spi_voice <= '0;
      r_spi_code  <= '0;
    end else begin
      r_spi_flag <= w_issue;
      if (w_slot && w_contend) begin
        r_prefer_b <= ~r_prefer_b;
      end
      if (w_issue) begin
        r_spi_voice <= w_win_voice;
        r_spi_code  <= w_win_code;
      end
    end
  end

`ifdef DDS_SCHED_WRCNT_EN
  logic [WRCNT_W-1:0] r_write_count;

  // Saturating count of issued write strobes; clear wins over increment.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_write_count <= '0;
    end else if (i_count_clr) begin
      r_write_count <= '0;
    end else if (r_spi_flag && (r_write_count != '1)) begin
      r_write_count <= r_write_count + WRCNT_W'(1);
    end
  end

  assign o_write_count = r_write_count;
`endif

  assign o_pipeline_state  = r_state;
  assign o_voice_index     = r_index;
  assign o_frame_start     = r_frame_start;
  assign o_SPI_flag        = r_spi_flag;
  assign o_SPI_voice_index = r_spi_voice;
  assign o_SPI_tuning_code = r_spi_code;

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Directed bench for dds_voice_scheduler: sequencing, arbitration, write issue, reset.
module tb_dds_voice_scheduler;

  localparam int unsigned NV = 8;
  localparam int unsigned VW = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    o_pipeline_state;
  logic [VW-1:0] o_voice_index;
  logic          o_frame_start;
  logic          va, vb;
  logic          o_ready_a, o_ready_b;
  logic [VW-1:0] voice_a, voice_b;
  logic [CW-1:0] code_a, code_b;
  logic          o_SPI_flag;
  logic [VW-1:0] o_SPI_voice_index;
  logic [CW-1:0] o_SPI_tuning_code;
`ifdef DDS_SCHED_WRCNT_EN
  logic          count_clr;
  logic [15:0]   o_write_count;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state;
  int   m_idx;
  logic m_fs;

  always #5 clk = ~clk;

  dds_voice_scheduler u_dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_enable          (en),
    .o_pipeline_state  (o_pipeline_state),
    .o_voice_index     (o_voice_index),
    .o_frame_start     (o_frame_start),
    .i_valid_a         (va),
    .o_ready_a         (o_ready_a),
    .i_voice_a         (voice_a),
    .i_code_a          (code_a),
    .i_valid_b         (vb),
    .o_ready_b         (o_ready_b),
    .i_voice_b         (voice_b),
    .i_code_b          (code_b),
`ifdef DDS_SCHED_WRCNT_EN
    .i_count_clr       (count_clr),
    .o_write_count     (o_write_count),
`endif
    .o_SPI_flag        (o_SPI_flag),
    .o_SPI_voice_index (o_SPI_voice_index),
    .o_SPI_tuning_code (o_SPI_tuning_code)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, step the sequencing model, compare slot/index/frame pulse.
  task automatic cyc();
    @(negedge clk);
    if (en) begin
      m_fs = (m_state == 3) && (m_idx == NV - 1);
      if (m_state == 3) m_idx = (m_idx + 1) % NV;
      m_state = (m_state + 1) % 4;
    end else begin
      m_fs = 1'b0;
    end
    check("state", 64'(o_pipeline_state), 64'(m_state));
    check("index", 64'(o_voice_index), 64'(m_idx));
    check("frame_start", 64'(o_frame_start), 64'(m_fs));
  endtask

  task automatic wait_state(input int s);
    int k = 0;
    while (m_state != s && k < 8) begin
      cyc();
      k++;
    end
    check("reach_state", 64'(o_pipeline_state), 64'(s));
  endtask

  task automatic expect_write(input logic [VW-1:0] v, input logic [CW-1:0] c);
    check("spi_flag", 64'(o_SPI_flag), 64'd1);
    check("spi_voice", 64'(o_SPI_voice_index), 64'(v));
    check("spi_code", 64'(o_SPI_tuning_code), 64'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; va = 1'b0; vb = 1'b0;
    voice_a = '0; voice_b = '0; code_a = '0; code_b = '0;
`ifdef DDS_SCHED_WRCNT_EN
    count_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_state", 64'(o_pipeline_state), 64'd0);
    check("rst_index", 64'(o_voice_index), 64'd0);
    check("rst_fs", 64'(o_frame_start), 64'd0);
    check("rst_flag", 64'(o_SPI_flag), 64'd0);
    check("rst_voice", 64'(o_SPI_voice_index), 64'd0);
    check("rst_code", 64'(o_SPI_tuning_code), 64'd0);
    check("rst_ready_a", 64'(o_ready_a), 64'd1);
    check("rst_ready_b", 64'(o_ready_b), 64'd1);

    rst_n = 1'b1; en = 1'b1; m_state = 0; m_idx = 0; m_fs = 1'b0;
    repeat (40) cyc();

    // Single A request entered during state 1
    wait_state(1);
    va = 1'b1; voice_a = 8'd5; code_a = 32'd1000000;
    cyc();
    check("a_ready_low", 64'(o_ready_a), 64'd0);
    va = 1'b0;
    cyc();
    check("a_noflag_st3", 64'(o_SPI_flag), 64'd0);
    cyc();
    expect_write(8'd5, 32'd1000000);
    check("a_ready_back", 64'(o_ready_a), 64'd1);
    cyc();
    check("a_flag_single", 64'(o_SPI_flag), 64'd0);
    check("a_voice_hold", 64'(o_SPI_voice_index), 64'd5);

    // Contention, pointer starts at A
    wait_state(1);
    va = 1'b1; voice_a = 8'd2; code_a = 32'd100;
    vb = 1'b1; voice_b = 8'd3; code_b = 32'd200;
    cyc();
    check("ab_ready_a", 64'(o_ready_a), 64'd0);
    check("ab_ready_b", 64'(o_ready_b), 64'd0);
    va = 1'b0; vb = 1'b0;
    wait_state(0);
    expect_write(8'd2, 32'd100);
    check("ab1_ready_a", 64'(o_ready_a), 64'd1);
    check("ab1_ready_b", 64'(o_ready_b), 64'd0);
    cyc();
    check("ab_gap_flag", 64'(o_SPI_flag), 64'd0);
    wait_state(0);
    expect_write(8'd3, 32'd200);
    check("ab2_ready_b", 64'(o_ready_b), 64'd1);

    // Contention again, B now preferred
    wait_state(1);
    va = 1'b1; voice_a = 8'd4; code_a = 32'd400;
    vb = 1'b1; voice_b = 8'd6; code_b = 32'd600;
    cyc();
    va = 1'b0; vb = 1'b0;
    wait_state(0);
    expect_write(8'd6, 32'd600);
    cyc();
    wait_state(0);
    expect_write(8'd4, 32'd400);

    // Out-of-range target from B
    wait_state(1);
    vb = 1'b1; voice_b = 8'd9; code_b = 32'd999;
    cyc();
    check("oor_ready_low", 64'(o_ready_b), 64'd0);
    vb = 1'b0;
    wait_state(0);
    check("oor_flag", 64'(o_SPI_flag), 64'd0);
    check("oor_voice", 64'(o_SPI_voice_index), 64'd4);
    check("oor_code", 64'(o_SPI_tuning_code), 64'd400);
    check("oor_ready_back", 64'(o_ready_b), 64'd1);

    // Freeze with A pending
    wait_state(1);
    va = 1'b1; voice_a = 8'd1; code_a = 32'd77;
    cyc();
    va = 1'b0; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("frz_flag", 64'(o_SPI_flag), 64'd0);
      check("frz_ready_a", 64'(o_ready_a), 64'd0);
    end
    en = 1'b1;
    cyc();
    check("frz_st3_flag", 64'(o_SPI_flag), 64'd0);
    cyc();
    expect_write(8'd1, 32'd77);
`ifdef DDS_SCHED_WRCNT_EN
    cyc();
    check("wrcnt", 64'(o_write_count), 64'd6);
`endif

    // Reset mid-sweep with both pending
    wait_state(1);
    va = 1'b1; voice_a = 8'd2; code_a = 32'd11;
    vb = 1'b1; voice_b = 8'd3; code_b = 32'd22;
    cyc();
    va = 1'b0; vb = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_state", 64'(o_pipeline_state), 64'd0);
    check("mrst_index", 64'(o_voice_index), 64'd0);
    check("mrst_flag", 64'(o_SPI_flag), 64'd0);
    check("mrst_voice", 64'(o_SPI_voice_index), 64'd0);
    check("mrst_code", 64'(o_SPI_tuning_code), 64'd0);
    check("mrst_ready_a", 64'(o_ready_a), 64'd1);
    check("mrst_ready_b", 64'(o_ready_b), 64'd1);
`ifdef DDS_SCHED_WRCNT_EN
    check("mrst_wrcnt", 64'(o_write_count), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; m_state = 0; m_idx = 0; m_fs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("post_rst_flag", 64'(o_SPI_flag), 64'd0);
    end
    check("post_rst_ready_a", 64'(o_ready_a), 64'd1);
    check("post_rst_ready_b", 64'(o_ready_b), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
